// File: rtl/axi_wr_channel_push_pkg.sv
// Shared definitions for the AXI4-Lite write-channel push stage.
// Holds the response codes, the FSM state encodings and the address bit
// positions that the downstream pop/decoder stage also relies on.
package axi_wr_channel_push_pkg;

  // Write response codes
  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  // Address bit that marks a register/memory target
  localparam int REG_SPACE_BIT = 17;
  // Address bit the downstream stage uses to split register vs memory space
  localparam int REG_SEL_BIT   = 8;

  // Write-channel FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_W  = 3'd1,
    ST_WAIT_AW = 3'd2,
    ST_PUSH    = 3'd3,
    ST_RESP    = 3'd4
  } wr_state_e;

endpackage

// File: rtl/axi_wr_channel_push.sv
// AXI4-Lite single-beat write slave that pairs one AW beat with one W beat,
// pushes address and data together into the address/data FIFOs, then issues
// the B response. One transaction is outstanding at a time.
//
// Optional feature, macro AXI_DECERR_EN: writes whose captured address has
// bit REG_SPACE_BIT clear are not pushed and answer with DECERR. Without the
// macro every write is pushed and answers OKAY.
//
// Handshakes: a beat transfers on a rising Clk edge where valid && ready are
// both high. awready/wready/bvalid are decoded from the FSM state only and
// never depend on the matching valid, so the master may hold valid as long as
// it likes; the master must keep a raised valid and its payload stable until
// the transfer edge.
module axi_wr_channel_push
  import axi_wr_channel_push_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [1:0]            bresp,
  input  logic                  full_address,
  input  logic                  full_data,
  output logic                  wr_en_address,
  output logic                  wr_en_data,
  output logic [ADDR_WIDTH-1:0] address_fifo_o,
  output logic [DATA_WIDTH-1:0] data_fifo_o
);

  // State register is visible as state_q for checkers bound to this module.
  wr_state_e             state_q;
  wr_state_e             state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  decerr_q;

  logic aw_hs;
  logic w_hs;
  logic decerr_hit;
  logic push;
  logic push_exit;

  assign awready = (state_q == ST_IDLE) || (state_q == ST_WAIT_AW);
  assign wready  = (state_q == ST_IDLE) || (state_q == ST_WAIT_W);
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;

`ifdef AXI_DECERR_EN
  // Undecoded target: skip the push and answer DECERR.
  assign decerr_hit = ~addr_q[REG_SPACE_BIT];
`else
  // Every write is pushed; the pop stage filters undecoded addresses.
  assign decerr_hit = 1'b0;
`endif

  // Both FIFOs must have room so address and data are always pushed as a pair.
  assign push      = (state_q == ST_PUSH) && !decerr_hit && !full_address && !full_data;
  assign push_exit = (state_q == ST_PUSH) && (state_d == ST_RESP);

  // FIFO-side outputs: captured words only while the push strobe is high.
  assign wr_en_address  = push;
  assign wr_en_data     = push;
  assign address_fifo_o = push ? addr_q : '0;
  assign data_fifo_o    = push ? data_q : '0;

  // B channel: response held stable for the whole RESP state.
  assign bvalid = (state_q == ST_RESP);
  assign bresp  = ((state_q == ST_RESP) && decerr_q) ? BRESP_DECERR : BRESP_OKAY;

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (aw_hs && w_hs) state_d = ST_PUSH;
        else if (aw_hs)    state_d = ST_WAIT_W;
        else if (w_hs)     state_d = ST_WAIT_AW;
      end
      ST_WAIT_W: begin
        if (w_hs) state_d = ST_PUSH;
      end
      ST_WAIT_AW: begin
        if (aw_hs) state_d = ST_PUSH;
      end
      ST_PUSH: begin
        if (decerr_hit || push) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Capture each payload on its own handshake edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (aw_hs) addr_q <= awaddr;
      if (w_hs)  data_q <= wdata;
    end
  end

  // Latch the response kind as the FSM leaves PUSH.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)           decerr_q <= 1'b0;
    else if (push_exit) decerr_q <= decerr_hit;
  end

endmodule

// File: tb/tb_axi_wr_channel_push.sv
// Directed bench for axi_wr_channel_push: paired AW/W, W-before-AW, FIFO-full
// stall, B backpressure, DECERR handling (macro AXI_DECERR_EN) and reset in
// a wait state. Inputs change 1 ns after the rising edge; outputs are sampled
// on the falling edge.
module tb_axi_wr_channel_push;

  localparam int AW = 32;
  localparam int DW = 32;

  // Clock / reset
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  logic          awvalid = 1'b0;
  logic          awready;
  logic [AW-1:0] awaddr = '0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [DW-1:0] wdata = '0;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [1:0]    bresp;
  logic          full_address = 1'b0;
  logic          full_data = 1'b0;
  logic          wr_en_address;
  logic          wr_en_data;
  logic [AW-1:0] address_fifo_o;
  logic [DW-1:0] data_fifo_o;

  axi_wr_channel_push #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .Clk            (Clk),
    .Rst            (Rst),
    .awvalid        (awvalid),
    .awready        (awready),
    .awaddr         (awaddr),
    .wvalid         (wvalid),
    .wready         (wready),
    .wdata          (wdata),
    .bvalid         (bvalid),
    .bready         (bready),
    .bresp          (bresp),
    .full_address   (full_address),
    .full_data      (full_data),
    .wr_en_address  (wr_en_address),
    .wr_en_data     (wr_en_data),
    .address_fifo_o (address_fifo_o),
    .data_fifo_o    (data_fifo_o)
  );

  // Scoreboard state
  logic [AW+DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int push_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Driver helpers
  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_awready"}, 64'(awready), 64'd1);
    check({tag, "_wready"},  64'(wready),  64'd1);
    check({tag, "_bvalid"},  64'(bvalid),  64'd0);
    check({tag, "_bresp"},   64'(bresp),   64'd0);
    check({tag, "_wr_en"},   64'({wr_en_address, wr_en_data}), 64'd0);
    check({tag, "_fifo_o"},  {address_fifo_o, data_fifo_o}, 64'd0);
  endtask

  // Push monitor: every strobe must be a paired push matching the next expected word.
  always @(negedge Clk) begin
    if (Rst && (wr_en_address || wr_en_data)) begin
      logic [AW+DW-1:0] exp_word;
      push_cnt++;
      check("push_paired", 64'({wr_en_address, wr_en_data}), 64'd3);
      check("push_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        exp_word = exp_q.pop_front();
        check("push_word", {address_fifo_o, data_fifo_o}, exp_word);
      end
    end
  end

  int base_cnt;

  initial begin
    // Reset state
    sample();
    check_idle_outputs("reset");
    cycle();
    cycle();
    Rst = 1'b1;

    // 1: AW and W together
    cycle();
    awvalid = 1'b1; awaddr = 32'h0002_0100;
    wvalid  = 1'b1; wdata  = 32'hDEAD_BEEF;
    bready  = 1'b1;
    exp_q.push_back({32'h0002_0100, 32'hDEAD_BEEF});
    base_cnt = push_cnt;
    sample();
    check("t1_ready_pair", 64'({awready, wready}), 64'd3);
    cycle();                          // edge N: handshake
    awvalid = 1'b0; wvalid = 1'b0;
    sample();                         // N+1: push
    check("t1_push_n1", 64'(wr_en_address), 64'd1);
    check("t1_bvalid_n1", 64'(bvalid), 64'd0);
    cycle();
    sample();                         // N+2: response
    check("t1_bvalid_n2", 64'(bvalid), 64'd1);
    check("t1_bresp", 64'(bresp), 64'd0);
    check("t1_no_push_n2", 64'(wr_en_address), 64'd0);
    cycle();
    sample();
    check("t1_bvalid_drop", 64'(bvalid), 64'd0);
    check("t1_push_count", 64'(push_cnt - base_cnt), 64'd1);

    // 2: W three cycles ahead of AW
    base_cnt = push_cnt;
    wvalid = 1'b1; wdata = 32'h1234_5678;
    exp_q.push_back({32'h0002_0004, 32'h1234_5678});
    cycle();
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check("t2_wready_low", 64'(wready), 64'd0);
      check("t2_awready_high", 64'(awready), 64'd1);
      check("t2_no_push", 64'(wr_en_data), 64'd0);
      cycle();
    end
    awvalid = 1'b1; awaddr = 32'h0002_0004;
    cycle();
    awvalid = 1'b0;
    sample();
    check("t2_push", 64'(wr_en_data), 64'd1);
    cycle();
    sample();
    check("t2_bvalid", 64'(bvalid), 64'd1);
    cycle();
    sample();
    check("t2_push_count", 64'(push_cnt - base_cnt), 64'd1);

    // 3: data FIFO full for 5 cycles in PUSH, then 4: bready low for 4 cycles
    base_cnt = push_cnt;
    full_data = 1'b1; bready = 1'b0;
    awvalid = 1'b1; awaddr = 32'h0002_0300;
    wvalid  = 1'b1; wdata  = 32'hCAFE_0001;
    exp_q.push_back({32'h0002_0300, 32'hCAFE_0001});
    cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t3_stalled", 64'({wr_en_address, wr_en_data}), 64'd0);
      check("t3_stall_bvalid", 64'(bvalid), 64'd0);
      cycle();
    end
    full_data = 1'b0;
    sample();
    check("t3_push_after_full", 64'({wr_en_address, wr_en_data}), 64'd3);
    cycle();
    awvalid = 1'b1; awaddr = 32'h0002_0FF0;  // must not be accepted in RESP
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t4_bvalid_hold", 64'(bvalid), 64'd1);
      check("t4_bresp_hold", 64'(bresp), 64'd0);
      check("t4_ready_low", 64'({awready, wready}), 64'd0);
      cycle();
    end
    bready = 1'b1; awvalid = 1'b0;
    sample();
    check("t4_bvalid_last", 64'(bvalid), 64'd1);
    cycle();
    sample();
    check("t4_back_idle", 64'({awready, wready, bvalid}), 64'd6);
    check("t34_push_count", 64'(push_cnt - base_cnt), 64'd1);

    // 5: undecoded address
    base_cnt = push_cnt;
    awvalid = 1'b1; awaddr = 32'h0000_0100;
    wvalid  = 1'b1; wdata  = 32'h5555_AAAA;
`ifndef AXI_DECERR_EN
    exp_q.push_back({32'h0000_0100, 32'h5555_AAAA});
`endif
    cycle();
    awvalid = 1'b0; wvalid = 1'b0;
    sample();
    cycle();
    sample();
    check("t5_bvalid", 64'(bvalid), 64'd1);
`ifdef AXI_DECERR_EN
    check("t5_bresp", 64'(bresp), 64'd3);
    check("t5_push_count", 64'(push_cnt - base_cnt), 64'd0);
`else
    check("t5_bresp", 64'(bresp), 64'd0);
    check("t5_push_count", 64'(push_cnt - base_cnt), 64'd1);
`endif
    cycle();
    sample();
    check("t5_bresp_after", 64'(bresp), 64'd0);

    // 6: reset while in WAIT_W
    base_cnt = push_cnt;
    awvalid = 1'b1; awaddr = 32'h0002_0200;
    cycle();
    awvalid = 1'b0;
    sample();
    check("t6_wait_w", 64'({awready, wready}), 64'd1);
    #1 Rst = 1'b0;
    #1;
    check_idle_outputs("t6_reset");
    cycle();
    Rst = 1'b1;
    wvalid = 1'b1; wdata = 32'h9999_0000;  // lone W after reset must not complete a push
    cycle();
    wvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample();
      check("t6_no_push", 64'({wr_en_address, wr_en_data, bvalid}), 64'd0);
      check("t6_wait_aw", 64'({awready, wready}), 64'd2);
      cycle();
    end
    check("t6_push_count", 64'(push_cnt - base_cnt), 64'd0);
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
